stack_alu: RTL
==============

// Module: stack_alu
// PURPOSE
//  Stack-based 16-bit accumulator ALU; the DUT end of the ALU bench interface (driver pushes/pops/ops, monitor reads data_out/zero).
//  Operands are pushed onto an internal LIFO. Ops consume/replace top-of-stack (TOS) and next-on-stack (NOS).
//  Registered TOS is presented on data_out every cycle.
// PARAMETERS
//  DW     16  data width (data_in, data_out, stack entries)
//  DEPTH  8   stack entries (>=2); pointer width $clog2(DEPTH+1)
// PORTS
//  clk       in   1   clock, all state on posedge
//  reset     in   1   asynchronous, active-high; clears all state
//  ce        in   1   clock enable; ce=0 -> no state change (clr, push, pop, op ignored)
//  clr       in   1   synchronous clear (qualified by ce)
//  data_in   in   DW  operand for push
//  push      in   1   push data_in
//  pop       in   1   discard TOS
//  op        in   8   operation code (see BEHAVIOUR); 0x00 = NOP
//  data_out  out  DW  registered TOS; 0 when empty
//  zero      out  1   registered, =1 when data_out==0 (incl. empty)
//  depth     out  $clog2(DEPTH+1)  current entry count
//  err       out  1   sticky error flag, cleared by reset/clr only
// BEHAVIOUR
//  Reset: data_out=0, zero=1, depth=0, err=0, stack contents don't-care. Reset mid-operation aborts it; no partial update.
//  Latency: one cycle. Effect of cycle-N inputs is visible on outputs after posedge N.
//  Per-cycle priority (ce=1): clr > push/pop > op. Lower-priority inputs are ignored that cycle, with no error.
//  clr: depth=0, data_out=0, zero=1, err=0.
//  push only: if depth<DEPTH, TOS<=data_in and depth++. If full: ignored, err=1.
//  pop only: if depth>0, depth-- and data_out<=new TOS (0 if empty). If empty: ignored, err=1.
//  push+pop: if depth>0, TOS replaced by data_in (depth unchanged). If empty: behaves as push.
//  Binary ops (need depth>=2): result replaces NOS, depth-- (result becomes TOS).
//   0x01 ADD  NOS+TOS mod 2^DW
//   0x02 SUB  NOS-TOS mod 2^DW
//   0x03 AND
//   0x04 OR
//   0x05 XOR
//   0x06 MUL  low DW bits of NOS*TOS
//  Unary ops (need depth>=1): result replaces TOS, depth unchanged.
//   0x10 NOT
//   0x11 NEG (two's complement)
//   0x12 SHL by 1, zero fill
//   0x13 SHR by 1, logical
//  Stack ops:
//   0x20 DUP  needs 1<=depth<DEPTH; depth++
//   0x21 SWAP needs depth>=2; exchange TOS/NOS
//  Insufficient depth, DUP on full, or undefined opcode: no state change, err=1.
//  zero always tracks the registered data_out; never combinational from inputs.
//  Stack stored as DEPTH-entry register array indexed by depth-1. TOS is also held in the data_out register.
// CONFIGURATION
//  STACK_ALU_MUL_EN defined: op 0x06 performs MUL as above (one DWxDW multiplier, single cycle).
//  STACK_ALU_MUL_EN undefined: no multiplier built. 0x06 is an undefined opcode: no state change, err=1.
// TESTING
//  reset=1 mid-stream, then release -> data_out=0, zero=1, depth=0, err=0.
//  push 5, push 3, op=0x02 -> data_out=2, depth=1.
//  push 3, op=0x11 -> 0xFFFD.
//  ce=0 with push asserted -> no change.
//  push 0x1234, op=0x20 (DUP), op=0x05 (XOR) -> data_out=0, zero=1, depth=1.
//  DEPTH+1 pushes -> depth=DEPTH, err=1, data_out=last accepted value.
//  clr -> depth=0, err=0.
//  pop on empty -> err=1.
//  push 7 with push+pop in same cycle (data_in=9) -> data_out=9, depth=1.
//  op=0x01 with depth=1 -> err=1, data_out unchanged.
//  MUL: push 0x0100, push 0x0101, op=0x06 -> 0x0100 with STACK_ALU_MUL_EN defined.
//  MUL without STACK_ALU_MUL_EN -> depth=2, err=1.
//  op=0x7F (undefined) -> err=1, no state change. Further cycles keep err=1 until clr.

Source files
------------

// File: rtl/stack_alu.sv
// ----------------------------------------------------------------------------
// stack_alu
//   Stack-based accumulator ALU. Operands are pushed onto an internal LIFO;
//   operations consume/replace top-of-stack (TOS) and next-on-stack (NOS).
//   The TOS is kept in a dedicated register that drives data_out directly, so
//   data_out and zero are registered outputs.
//
//   Optional feature macro: STACK_ALU_MUL_EN
//     defined   -> op 0x06 is MUL (low DW bits of NOS*TOS)
//     undefined -> no multiplier; 0x06 is an undefined opcode (err=1)
//
// Ports
//   clk       in   clock, all state on posedge
//   reset     in   asynchronous active-high reset
//   ce        in   clock enable; 0 freezes all state
//   clr       in   synchronous clear (qualified by ce)
//   data_in   in   DW-bit operand for push
//   push      in   push data_in
//   pop       in   discard TOS
//   op        in   8-bit opcode, 0x00 = NOP
//   data_out  out  registered TOS (0 when empty)
//   zero      out  registered, 1 when data_out == 0
//   depth     out  current entry count
//   err       out  sticky error, cleared by reset/clr
// ----------------------------------------------------------------------------
module stack_alu #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         clr,
    input  logic [DW-1:0]                data_in,
    input  logic                         push,
    input  logic                         pop,
    input  logic [7:0]                   op,
    output logic [DW-1:0]                data_out,
    output logic                         zero,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err
);

    localparam int unsigned PW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] CNT_ZERO = '0;
    localparam logic [PW-1:0] CNT_ONE  = PW'(1);
    localparam logic [PW-1:0] CNT_TWO  = PW'(2);
    localparam logic [PW-1:0] CNT_FULL = PW'(DEPTH);

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_ADD  = 8'h01,
        OP_SUB  = 8'h02,
        OP_AND  = 8'h03,
        OP_OR   = 8'h04,
        OP_XOR  = 8'h05,
        OP_MUL  = 8'h06,
        OP_NOT  = 8'h10,
        OP_NEG  = 8'h11,
        OP_SHL  = 8'h12,
        OP_SHR  = 8'h13,
        OP_DUP  = 8'h20,
        OP_SWAP = 8'h21
    } opcode_e;

    // Stack storage, entry depth-1 is the TOS (mirrored in tos_q)
    logic [DW-1:0] stack_q [DEPTH];
    logic [DW-1:0] stack_d [DEPTH];

    logic [DW-1:0] tos_q, tos_d;
    logic [PW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic          zero_q, zero_d;

    logic [DW-1:0] nos;
    logic [DW-1:0] alu_res;

    // Two stack write ports; the second is only needed by SWAP
    logic          wa_en, wb_en;
    logic [PW-1:0] wa_idx, wb_idx;
    logic [DW-1:0] wa_val, wb_val;

    logic has1, has2, full;

    assign has1 = (depth_q != CNT_ZERO);
    assign has2 = (depth_q >= CNT_TWO);
    assign full = (depth_q == CNT_FULL);

    // NOS read mux (entry depth-2); only meaningful when has2
    always_comb begin
        nos = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (PW'(i) == (depth_q - CNT_TWO)) begin
                nos = stack_q[i];
            end
        end
    end

    // Datapath: binary ops use NOS (left) and TOS (right); unary ops use TOS
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = nos + tos_q;
            OP_SUB:  alu_res = nos - tos_q;
            OP_AND:  alu_res = nos & tos_q;
            OP_OR:   alu_res = nos | tos_q;
            OP_XOR:  alu_res = nos ^ tos_q;
`ifdef STACK_ALU_MUL_EN
            OP_MUL:  alu_res = nos * tos_q;
`endif
            OP_NOT:  alu_res = ~tos_q;
            OP_NEG:  alu_res = '0 - tos_q;
            OP_SHL:  alu_res = {tos_q[DW-2:0], 1'b0};
            OP_SHR:  alu_res = {1'b0, tos_q[DW-1:1]};
            default: alu_res = '0;
        endcase
    end

    // Control: priority clr > push/pop > op
    always_comb begin
        tos_d   = tos_q;
        depth_d = depth_q;
        err_d   = err_q;
        wa_en   = 1'b0;
        wa_idx  = '0;
        wa_val  = '0;
        wb_en   = 1'b0;
        wb_idx  = '0;
        wb_val  = '0;

        if (ce) begin
            if (clr) begin
                tos_d   = '0;
                depth_d = '0;
                err_d   = 1'b0;
            end else if (push && pop) begin
                if (has1) begin
                    // Replace TOS in place
                    wa_en  = 1'b1;
                    wa_idx = depth_q - CNT_ONE;
                    wa_val = data_in;
                    tos_d  = data_in;
                end else begin
                    // Empty: behaves as a plain push (cannot be full)
                    wa_en   = 1'b1;
                    wa_idx  = CNT_ZERO;
                    wa_val  = data_in;
                    tos_d   = data_in;
                    depth_d = CNT_ONE;
                end
            end else if (push) begin
                if (!full) begin
                    wa_en   = 1'b1;
                    wa_idx  = depth_q;
                    wa_val  = data_in;
                    tos_d   = data_in;
                    depth_d = depth_q + CNT_ONE;
                end else begin
                    err_d = 1'b1;
                end
            end else if (pop) begin
                if (has1) begin
                    depth_d = depth_q - CNT_ONE;
                    tos_d   = has2 ? nos : '0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (op)
                    OP_NOP: ;
`ifdef STACK_ALU_MUL_EN
                    OP_MUL,
`endif
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        if (has2) begin
                            wa_en   = 1'b1;
                            wa_idx  = depth_q - CNT_TWO;
                            wa_val  = alu_res;
                            tos_d   = alu_res;
                            depth_d = depth_q - CNT_ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_NOT, OP_NEG, OP_SHL, OP_SHR: begin
                        if (has1) begin
                            wa_en  = 1'b1;
                            wa_idx = depth_q - CNT_ONE;
                            wa_val = alu_res;
                            tos_d  = alu_res;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_DUP: begin
                        if (has1 && !full) begin
                            wa_en   = 1'b1;
                            wa_idx  = depth_q;
                            wa_val  = tos_q;
                            depth_d = depth_q + CNT_ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_SWAP: begin
                        if (has2) begin
                            wa_en  = 1'b1;
                            wa_idx = depth_q - CNT_ONE;
                            wa_val = nos;
                            wb_en  = 1'b1;
                            wb_idx = depth_q - CNT_TWO;
                            wb_val = tos_q;
                            tos_d  = nos;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stack_d[i] = stack_q[i];
            if (wa_en && (PW'(i) == wa_idx)) begin
                stack_d[i] = wa_val;
            end
            if (wb_en && (PW'(i) == wb_idx)) begin
                stack_d[i] = wb_val;
            end
        end
    end

    assign zero_d = (tos_d == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            tos_q   <= tos_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    // Contents are don't-care after reset (depth=0 hides them), so no reset here
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
        end
    end

    assign data_out = tos_q;
    assign zero     = zero_q;
    assign depth    = depth_q;
    assign err      = err_q;

endmodule
